// File: rtl/pmp_csr_bank.sv
// PMP CSR bank: pmpcfg/pmpaddr storage with WARL legalization, lock rules
// and a one-cycle update pulse for the MMU.
module pmp_csr_bank #(
    parameter int unsigned PMP_ENTRIES = 16,
    parameter int unsigned XLEN        = 64,
    parameter int unsigned PA_BITS     = 56
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          CSRWriteM,
    input  logic                          StallW,
    input  logic [11:0]                   CSRAdrM,
    input  logic [XLEN-1:0]               CSRWriteValM,
    input  logic [1:0]                    PrivilegeModeM,
    output logic [XLEN-1:0]               CSRReadValM,
    output logic                          IllegalCSRAccessM,
    output logic [PMP_ENTRIES*8-1:0]      PMPCfg,
    output logic [PMP_ENTRIES*XLEN-1:0]   PMPAdr,
    output logic                          PMPUpdateM
);

    localparam int unsigned AW    = PA_BITS - 2;
    localparam int unsigned BYTES = XLEN / 8;

    logic [7:0]    cfg_q [PMP_ENTRIES];
    logic [7:0]    cfg_d [PMP_ENTRIES];
    logic [AW-1:0] adr_q [PMP_ENTRIES];
    logic [AW-1:0] adr_d [PMP_ENTRIES];
    logic          adr_lock [PMP_ENTRIES];
    logic          update_q;

    logic          is_cfg, is_adr, odd_cfg, commit, changed;
    logic [5:0]    adr_off;
    int unsigned   cfg_base, adr_idx;

    // Address decode and legality; commit only for legal, unstalled writes
    always_comb begin
        is_cfg            = (CSRAdrM[11:4] == 8'h3A);
        is_adr            = (CSRAdrM >= 12'h3B0) && (CSRAdrM <= 12'h3EF);
        // Low six bits of 0x3B0..0x3EF minus 0x30 wrap cleanly onto 0..63
        adr_off           = CSRAdrM[5:0] - 6'h30;
        adr_idx           = 32'(adr_off);
        // Both XLEN layouts put entry 4*k at the start of pmpcfg k
        cfg_base          = 32'(CSRAdrM[3:0]) << 2;
        odd_cfg           = (XLEN == 64) && is_cfg && CSRAdrM[0];
        IllegalCSRAccessM = (is_cfg || is_adr) && ((PrivilegeModeM != 2'b11) || odd_cfg);
        commit            = CSRWriteM && !StallW && !IllegalCSRAccessM;
    end

    // An address word is frozen by its own L bit or by a locked TOR entry above it
    always_comb begin
        for (int unsigned i = 0; i < PMP_ENTRIES; i++) begin
            adr_lock[i] = cfg_q[i][7];
        end
        for (int unsigned i = 0; i + 1 < PMP_ENTRIES; i++) begin
            if (cfg_q[i+1][7] && (cfg_q[i+1][4:3] == 2'b01)) begin
                adr_lock[i] = 1'b1;
            end
        end
    end

    // Next-state: per-byte legalized cfg writes and masked address writes
    always_comb begin
        logic [7:0]        wb;
        int unsigned       off;
        cfg_d   = cfg_q;
        adr_d   = adr_q;
        changed = 1'b0;
        wb      = '0;
        off     = 0;
        for (int unsigned i = 0; i < PMP_ENTRIES; i++) begin
            if (commit && is_cfg && (i >= cfg_base) && (i < cfg_base + BYTES)
                && !cfg_q[i][7]) begin
                off    = i - cfg_base;
                wb     = CSRWriteValM[8*off +: 8];
                wb[6:5] = 2'b00;
                // W without R is reserved; drop W
                if (wb[1] && !wb[0]) begin
                    wb[1] = 1'b0;
                end
                cfg_d[i] = wb;
            end
            if (commit && is_adr && (adr_idx == i) && !adr_lock[i]) begin
                adr_d[i] = CSRWriteValM[AW-1:0];
            end
            if ((cfg_d[i] != cfg_q[i]) || (adr_d[i] != adr_q[i])) begin
                changed = 1'b1;
            end
        end
    end

    // State registers with synchronous reset taking priority over writes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < PMP_ENTRIES; i++) begin
                cfg_q[i] <= '0;
                adr_q[i] <= '0;
            end
            update_q <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            adr_q    <= adr_d;
            update_q <= changed;
        end
    end

    // Combinational read mux; unimplemented entries and odd RV64 pmpcfg read 0
    always_comb begin
        CSRReadValM = '0;
        for (int unsigned i = 0; i < PMP_ENTRIES; i++) begin
            if (is_cfg && !odd_cfg && (i >= cfg_base) && (i < cfg_base + BYTES)) begin
                CSRReadValM[8*(i-cfg_base) +: 8] = cfg_q[i];
            end
            if (is_adr && (adr_idx == i)) begin
                CSRReadValM[AW-1:0] = adr_q[i];
            end
        end
    end

    // Flatten stored state onto the per-entry decoder buses
    always_comb begin
        PMPAdr = '0;
        for (int unsigned i = 0; i < PMP_ENTRIES; i++) begin
            PMPCfg[8*i +: 8]     = cfg_q[i];
            PMPAdr[XLEN*i +: AW] = adr_q[i];
        end
    end

    assign PMPUpdateM = update_q;

endmodule

// File: tb/tb_pmp_csr_bank.sv
// Self-checking bench for pmp_csr_bank: directed scenarios then random
// CSR traffic compared against an array-based reference model.
module tb_pmp_csr_bank;

    localparam int unsigned N  = 16;
    localparam int unsigned XL = 64;
    localparam int unsigned PA = 56;

    logic              clk;
    logic              reset;
    logic              CSRWriteM;
    logic              StallW;
    logic [11:0]       CSRAdrM;
    logic [XL-1:0]     CSRWriteValM;
    logic [1:0]        PrivilegeModeM;
    logic [XL-1:0]     CSRReadValM;
    logic              IllegalCSRAccessM;
    logic [N*8-1:0]    PMPCfg;
    logic [N*XL-1:0]   PMPAdr;
    logic              PMPUpdateM;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [7:0]  mcfg [N];
    logic [63:0] madr [N];

    pmp_csr_bank #(
        .PMP_ENTRIES (N),
        .XLEN        (XL),
        .PA_BITS     (PA)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .CSRWriteM         (CSRWriteM),
        .StallW            (StallW),
        .CSRAdrM           (CSRAdrM),
        .CSRWriteValM      (CSRWriteValM),
        .PrivilegeModeM    (PrivilegeModeM),
        .CSRReadValM       (CSRReadValM),
        .IllegalCSRAccessM (IllegalCSRAccessM),
        .PMPCfg            (PMPCfg),
        .PMPAdr            (PMPAdr),
        .PMPUpdateM        (PMPUpdateM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < N; i++) begin
            mcfg[i] = 8'h00;
            madr[i] = 64'h0;
        end
    endfunction

    function automatic bit m_illegal(input int a, input int p);
        bit in_pmp;
        in_pmp = (a >= 'h3A0) && (a <= 'h3EF);
        return in_pmp && ((p != 3) || ((a <= 'h3AF) && (a % 2 == 1)));
    endfunction

    function automatic logic [7:0] m_legal(input logic [7:0] v);
        logic [7:0] r;
        r = v & 8'h9F;
        if ((r & 8'h03) == 8'h02) r = r & 8'hFD;
        return r;
    endfunction

    function automatic logic [63:0] m_read(input int a);
        logic [63:0] r;
        int base;
        r = 64'h0;
        if (a >= 'h3A0 && a <= 'h3AF && (a % 2 == 0)) begin
            base = (a - 'h3A0) * 4;
            for (int b = 0; b < 8; b++)
                if (base + b < N) r[8*b +: 8] = mcfg[base + b];
        end else if (a >= 'h3B0 && a <= 'h3EF) begin
            if (a - 'h3B0 < N) r = madr[a - 'h3B0];
        end
        return r;
    endfunction

    // Applies one committed write to the model; returns whether anything changed
    function automatic bit m_write(input int a, input logic [63:0] v, input int p);
        bit chg;
        int base, idx;
        logic [7:0] nb;
        logic [63:0] nv;
        bit lock;
        chg = 0;
        if (m_illegal(a, p)) return 0;
        if (a >= 'h3A0 && a <= 'h3AF) begin
            base = (a - 'h3A0) * 4;
            for (int b = 0; b < 8; b++) begin
                if (base + b < N && mcfg[base + b][7] == 1'b0) begin
                    nb = m_legal(v[8*b +: 8]);
                    if (nb != mcfg[base + b]) chg = 1;
                    mcfg[base + b] = nb;
                end
            end
        end else if (a >= 'h3B0 && a <= 'h3EF) begin
            idx = a - 'h3B0;
            if (idx < N) begin
                lock = mcfg[idx][7];
                if (idx + 1 < N && mcfg[idx+1][7] && mcfg[idx+1][4:3] == 2'b01) lock = 1;
                if (!lock) begin
                    nv = v % (64'd1 << (PA - 2));
                    if (nv != madr[idx]) chg = 1;
                    madr[idx] = nv;
                end
            end
        end
        return chg;
    endfunction

    task automatic chk_state(input string tag);
        logic [N*8-1:0]  ecfg;
        logic [N*XL-1:0] eadr;
        for (int i = 0; i < N; i++) begin
            ecfg[8*i +: 8]   = mcfg[i];
            eadr[XL*i +: XL] = madr[i];
        end
        chk({tag, "_cfg"}, PMPCfg, ecfg);
        chk({tag, "_adr"}, PMPAdr, eadr);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        CSRWriteM = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_clear();
        chk("rst_pulse", PMPUpdateM, 1'b0);
    endtask

    // One CSR write, optional stall cycles, then pulse/state/readback checks
    task automatic wr(input string tag, input int a, input logic [63:0] v, input int p,
                      input int stalls);
        bit exp_chg;
        CSRAdrM        = a[11:0];
        CSRWriteValM   = v;
        PrivilegeModeM = p[1:0];
        CSRWriteM      = 1'b1;
        StallW         = (stalls > 0);
        #1;
        chk({tag, "_illegal"}, IllegalCSRAccessM, m_illegal(a, p));
        for (int s = 0; s < stalls; s++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_pulse"}, PMPUpdateM, 1'b0);
            chk_state({tag, "_stall"});
        end
        StallW  = 1'b0;
        exp_chg = m_write(a, v, p);
        @(posedge clk); #1;
        CSRWriteM = 1'b0;
        chk({tag, "_pulse"}, PMPUpdateM, exp_chg);
        chk_state(tag);
        PrivilegeModeM = 2'b11;
        #1;
        chk({tag, "_read"}, CSRReadValM, m_read(a));
    endtask

    initial begin
        int a, p, st;
        logic [63:0] v;
        m_clear();
        StallW         = 1'b0;
        PrivilegeModeM = 2'b11;

        // Reset wins over a simultaneous write
        reset        = 1'b1;
        CSRWriteM    = 1'b1;
        CSRAdrM      = 12'h3B0;
        CSRWriteValM = 64'h1234;
        @(posedge clk); #1;
        reset     = 1'b0;
        CSRWriteM = 1'b0;
        chk("rst_adr0", PMPAdr[63:0], 64'h0);
        chk("rst_pulse", PMPUpdateM, 1'b0);
        chk_state("rst");

        // WARL: 0x62 legalizes to 0x00, no change, no pulse
        wr("warl", 'h3A0, 64'h62, 3, 0);
        chk("warl_cfg0", PMPCfg[7:0], 8'h00);

        // Locked TOR entry 1 freezes pmpaddr0 and pmpaddr1
        wr("tor_cfg", 'h3A0, 64'h8900, 3, 0);
        chk("tor_cfg1", PMPCfg[15:8], 8'h89);
        wr("tor_adr0", 'h3B0, 64'h1000, 3, 0);
        wr("tor_adr1", 'h3B1, 64'h2000, 3, 0);
        chk("tor_adr01", PMPAdr[127:0], 128'h0);

        // Partial lock: byte0 locked, byte1 updates
        do_reset();
        wr("plock_a", 'h3A0, 64'h80, 3, 0);
        wr("plock_b", 'h3A0, 64'h0F0F, 3, 0);
        chk("plock_bytes", PMPCfg[15:0], 16'h0F80);

        // Privilege / illegal / unimplemented
        wr("smode", 'h3B2, 64'h5, 1, 0);
        CSRAdrM = 12'h3A1;
        #1;
        chk("odd_cfg_illegal", IllegalCSRAccessM, 1'b1);
        wr("unimpl", 'h3C5, 64'hABC, 3, 0);

        // Stalled full-width pmpaddr write commits after release, masked to PA_BITS-2
        wr("stall", 'h3B3, 64'hFFFF_FFFF_FFFF_FFFF, 3, 2);
        chk("stall_val", PMPAdr[4*64-1:3*64], (64'd1 << 54) - 64'd1);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if (n % 60 == 59) do_reset();
            if ($urandom_range(0, 9) == 0) a = int'($urandom_range(0, 12'hFFF));
            else a = 'h3A0 + int'($urandom_range(0, 79));
            v = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) v = v & ~64'h8080_8080_8080_8080;
            p  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : 3;
            st = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            wr("rnd", a, v, p, st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
